decoder: RTL and testbench

- 2-to-4 line decoder with active-high enable and one-hot outputs.
- Select is {a,b}, with a as MSB; en gates all outputs.
- Outputs are registered on the single system clock.
- Used wherever a 2-bit select must drive four mutually exclusive strobe lines.

---
 rtl/decoder.sv | 52 +++++
 tb/tb_decoder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// 2-to-4 line decoder with enable; select is {a,b} with a as MSB.
// Output can be registered or combinational, and active-high or active-low.
module decoder #(
    parameter int REG_OUT        = 1,
    parameter int OUT_ACTIVE_LOW = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic en,
    output logic D0,
    output logic D1,
    output logic D2,
    output logic D3
);

    localparam logic [3:0] POL = (OUT_ACTIVE_LOW != 0) ? 4'b1111 : 4'b0000;

    logic [3:0] dec;
    logic [3:0] dout;

    always_comb begin
        dec = '0;
        if (en) begin
            dec[{a, b}] = 1'b1;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            // Reset value is the deasserted level, which follows polarity.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dout <= POL;
                end else begin
                    dout <= dec ^ POL;
                end
            end
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk & rst_n;
            assign dout = dec ^ POL;
        end
    endgenerate

    assign D0 = dout[0];
    assign D1 = dout[1];
    assign D2 = dout[2];
    assign D3 = dout[3];

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: registered, active-low and combinational
// instances share stimulus; expected results flow through scoreboard queues.
module tb_decoder;

    logic clk;
    logic rst_n;
    logic a;
    logic b;
    logic en;

    logic d0_r, d1_r, d2_r, d3_r;
    logic d0_l, d1_l, d2_l, d3_l;
    logic d0_c, d1_c, d2_c, d3_c;

    int checks;
    int errors;

    logic [3:0] exp_q[$];
    logic [3:0] exp_lo_q[$];

    decoder #(.REG_OUT(1), .OUT_ACTIVE_LOW(0)) u_reg (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en),
        .D0(d0_r), .D1(d1_r), .D2(d2_r), .D3(d3_r)
    );

    decoder #(.REG_OUT(1), .OUT_ACTIVE_LOW(1)) u_lo (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en),
        .D0(d0_l), .D1(d1_l), .D2(d2_l), .D3(d3_l)
    );

    decoder #(.REG_OUT(0), .OUT_ACTIVE_LOW(0)) u_comb (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en),
        .D0(d0_c), .D1(d1_c), .D2(d2_c), .D3(d3_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model(input logic e, input logic aa, input logic bb);
        logic [3:0] r;
        r = 4'b0000;
        if (e) begin
            case ({aa, bb})
                2'b00: r = 4'b0001;
                2'b01: r = 4'b0010;
                2'b10: r = 4'b0100;
                default: r = 4'b1000;
            endcase
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got D3..D0=%b expected %b", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, check the combinational copy, then compare
    // the registered copies against the queued expectation after the edge.
    task automatic step(input string tag, input logic r, input logic e,
                        input logic aa, input logic bb);
        logic [3:0] exp;
        @(negedge clk);
        rst_n = r;
        en    = e;
        a     = aa;
        b     = bb;
        #1;
        check({tag, "/comb"}, {d3_c, d2_c, d1_c, d0_c}, model(e, aa, bb));
        exp = r ? model(e, aa, bb) : 4'b0000;
        exp_q.push_back(exp);
        exp_lo_q.push_back(~exp);
        @(posedge clk);
        #1;
        check({tag, "/reg"}, {d3_r, d2_r, d1_r, d0_r}, exp_q.pop_front());
        check({tag, "/lo"},  {d3_l, d2_l, d1_l, d0_l}, exp_lo_q.pop_front());
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        en     = 1'b0;
        a      = 1'b0;
        b      = 1'b0;

        step("rst0", 1'b0, 1'b1, 1'b1, 1'b1);
        step("rst1", 1'b0, 1'b1, 1'b1, 1'b1);
        step("rel",  1'b1, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 4; i++) begin
            logic [1:0] s;
            s = 2'(i);
            step($sformatf("en_sel%0d", i), 1'b1, 1'b1, s[1], s[0]);
        end
        for (int i = 0; i < 4; i++) begin
            logic [1:0] s;
            s = 2'(i);
            step($sformatf("dis_sel%0d", i), 1'b1, 1'b0, s[1], s[0]);
        end

        // Mid-cycle select glitch must not reach registered outputs.
        step("hold_pre", 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        a = 1'b1;
        b = 1'b1;
        #1;
        check("hold_mid/reg",  {d3_r, d2_r, d1_r, d0_r}, 4'b0001);
        check("hold_mid/lo",   {d3_l, d2_l, d1_l, d0_l}, 4'b1110);
        check("hold_mid/comb", {d3_c, d2_c, d1_c, d0_c}, 4'b1000);
        a = 1'b0;
        b = 1'b0;
        #1;
        check("hold_back/reg", {d3_r, d2_r, d1_r, d0_r}, 4'b0001);
        step("hold_post", 1'b1, 1'b1, 1'b0, 1'b0);

        step("sim_en",    1'b1, 1'b1, 1'b1, 1'b0);
        step("sim_rst",   1'b0, 1'b1, 1'b0, 1'b1);
        step("sim_rel",   1'b1, 1'b1, 1'b1, 1'b0);
        step("sim_endrop", 1'b1, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            logic [2:0] v;
            v = 3'($urandom_range(0, 7));
            step($sformatf("rnd%0d", i), ($urandom_range(0, 5) != 0), v[2], v[1], v[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
